ahb_rr_arbiter: RTL and testbench

//  Shares one AHB3-Lite slave port (RAM, peripheral bus) between NUM_MASTERS AHB3-Lite masters.

---
 rtl/ahb_rr_arbiter_pkg.sv | 27 ++
 rtl/ahb_rr_pick.sv | 34 +++
 rtl/ahb_rr_arbiter.sv | 139 +++++++++++++
 tb/tb_ahb_rr_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_rr_arbiter_pkg.sv
// Shared encodings and types for the AHB3-Lite round-robin arbiter.
package p_ahb_arb;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_DATA
  } arb_state_e;

  // Width of the captured address; instances must use AW <= CAP_AW.
  localparam int CAP_AW = 32;

  typedef struct packed {
    logic [CAP_AW-1:0] addr;
    logic [2:0]        size;
    logic              write;
    logic              lock;
  } cap_req_t;

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational N-way round-robin picker with lock hold on the last winner.
module ahb_rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]                  req,
  input  logic [(N>1?$clog2(N):1)-1:0]  last,
  input  logic                          lock,
  output logic [(N>1?$clog2(N):1)-1:0]  grant,
  output logic                          valid
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  int idx;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    grant = last;
    valid = 1'b0;
    idx   = 0;
    if (lock && req[last]) begin
      valid = 1'b1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(last) + k) % N;
        if (!valid && req[IW'(idx)]) begin
          grant = IW'(idx);
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Shares one AHB3-Lite slave between NUM_MASTERS masters; losers are captured,
// stalled through hready and replayed in round-robin order.
module ahb_rr_arbiter
  import p_ahb_arb::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32
) (
  input  logic          s_clk_i,
  input  logic          s_resetn_i,
  input  logic [AW-1:0] s_haddr_i     [NUM_MASTERS],
  input  logic [31:0]   s_hwdata_i    [NUM_MASTERS],
  input  logic [2:0]    s_hsize_i     [NUM_MASTERS],
  input  logic [1:0]    s_htrans_i    [NUM_MASTERS],
  input  logic          s_hwrite_i    [NUM_MASTERS],
  input  logic          s_hmastlock_i [NUM_MASTERS],
  input  logic          s_hsel_i      [NUM_MASTERS],
  output logic [31:0]   s_hrdata_o    [NUM_MASTERS],
  output logic          s_hready_o    [NUM_MASTERS],
  output logic          s_hresp_o     [NUM_MASTERS],
  output logic [AW-1:0] m_haddr_o,
  output logic [31:0]   m_hwdata_o,
  output logic [2:0]    m_hsize_o,
  output logic [1:0]    m_htrans_o,
  output logic          m_hwrite_o,
  output logic          m_hmastlock_o,
  output logic          m_hsel_o,
  input  logic [31:0]   m_hrdata_i,
  input  logic          m_hready_i,
  input  logic          m_hresp_i
);

  localparam int N  = NUM_MASTERS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  arb_state_e     state_q [N];
  arb_state_e     state_d [N];
  cap_req_t       cap_q   [N];
  cap_req_t       fwd;
  logic [N-1:0]   own, live, req, won;
  logic [IW-1:0]  r_last, r_dph_owner, pick_idx;
  logic           r_lock, r_dph_valid, pick_valid, grant;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      own[i]        = r_dph_valid && (r_dph_owner == IW'(i)) && (state_q[i] == ARB_DATA);
      s_hrdata_o[i] = m_hrdata_i;
      s_hready_o[i] = (state_q[i] == ARB_IDLE) || (own[i] && m_hready_i);
      s_hresp_o[i]  = own[i] && m_hresp_i;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      live[i] = s_hsel_i[i] && (s_htrans_i[i] == HTRANS_NONSEQ) && s_hready_o[i];
      req[i]  = live[i] || (state_q[i] == ARB_WAIT);
    end
  end

  ahb_rr_pick #(.N(N)) u_pick (
    .req   (req),
    .last  (r_last),
    .lock  (r_lock),
    .grant (pick_idx),
    .valid (pick_valid)
  );

  // A grant only commits when the slave can take a new address phase.
  assign grant = pick_valid && m_hready_i;

  always_comb begin
    for (int i = 0; i < N; i++) won[i] = grant && (pick_idx == IW'(i));
  end

  // A waiting master's live inputs have already moved on; replay its captured request.
  always_comb begin
    fwd = cap_q[pick_idx];
    if (state_q[pick_idx] != ARB_WAIT) begin
      fwd.addr  = CAP_AW'(s_haddr_i[pick_idx]);
      fwd.size  = s_hsize_i[pick_idx];
      fwd.write = s_hwrite_i[pick_idx];
      fwd.lock  = s_hmastlock_i[pick_idx];
    end
  end

  assign m_haddr_o     = AW'(fwd.addr);
  assign m_hsize_o     = fwd.size;
  assign m_hwrite_o    = fwd.write;
  assign m_hmastlock_o = pick_valid && fwd.lock;
  assign m_htrans_o    = pick_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign m_hsel_o      = pick_valid;
  assign m_hwdata_o    = s_hwdata_i[r_dph_owner];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        ARB_IDLE: if (live[i]) state_d[i] = won[i] ? ARB_DATA : ARB_WAIT;
        ARB_WAIT: if (won[i]) state_d[i] = ARB_DATA;
        ARB_DATA: if (m_hready_i) state_d[i] = !live[i] ? ARB_IDLE : (won[i] ? ARB_DATA : ARB_WAIT);
        default:  state_d[i] = ARB_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      for (int i = 0; i < N; i++) state_q[i] <= ARB_IDLE;
      r_last      <= IW'(N - 1);
      r_lock      <= 1'b0;
      r_dph_valid <= 1'b0;
      r_dph_owner <= '0;
    end else begin
      for (int i = 0; i < N; i++) state_q[i] <= state_d[i];
      if (m_hready_i) begin
        r_dph_valid <= pick_valid;
        if (pick_valid) begin
          r_dph_owner <= pick_idx;
          r_last      <= pick_idx;
          r_lock      <= fwd.lock;
        end
      end
    end
  end

  // NOTE: capture registers are plain storage qualified by state, so they need no reset.
  always_ff @(posedge s_clk_i) begin
    for (int i = 0; i < N; i++) begin
      if (live[i]) begin
        cap_q[i] <= '{addr:  CAP_AW'(s_haddr_i[i]),
                      size:  s_hsize_i[i],
                      write: s_hwrite_i[i],
                      lock:  s_hmastlock_i[i]};
      end
    end
  end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed self-checking bench: a 2-master arbiter for most scenarios, a 3-master one for fairness.
module tb_ahb_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  // 2-master instance
  logic [31:0] haddr [2];
  logic [31:0] hwdata [2];
  logic [2:0]  hsize [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic        hlock [2];
  logic        hsel [2];
  logic [31:0] hrdata [2];
  logic        hready [2];
  logic        hresp [2];
  logic [31:0] m_haddr, m_hwdata, m_hrdata;
  logic [2:0]  m_hsize;
  logic [1:0]  m_htrans;
  logic        m_hwrite, m_hlock, m_hsel, m_hready, m_hresp;

  // 3-master instance
  logic [31:0] haddr3 [3];
  logic [31:0] hwdata3 [3];
  logic [2:0]  hsize3 [3];
  logic [1:0]  htrans3 [3];
  logic        hwrite3 [3];
  logic        hlock3 [3];
  logic        hsel3 [3];
  logic [31:0] hrdata3 [3];
  logic        hready3 [3];
  logic        hresp3 [3];
  logic [31:0] m_haddr3, m_hwdata3;
  logic [2:0]  m_hsize3;
  logic [1:0]  m_htrans3;
  logic        m_hwrite3, m_hlock3, m_hsel3;

  int n_tests = 0;
  int n_fail  = 0;

  ahb_rr_arbiter #(.NUM_MASTERS(2), .AW(32)) dut (
    .s_clk_i(clk), .s_resetn_i(resetn),
    .s_haddr_i(haddr), .s_hwdata_i(hwdata), .s_hsize_i(hsize), .s_htrans_i(htrans),
    .s_hwrite_i(hwrite), .s_hmastlock_i(hlock), .s_hsel_i(hsel),
    .s_hrdata_o(hrdata), .s_hready_o(hready), .s_hresp_o(hresp),
    .m_haddr_o(m_haddr), .m_hwdata_o(m_hwdata), .m_hsize_o(m_hsize), .m_htrans_o(m_htrans),
    .m_hwrite_o(m_hwrite), .m_hmastlock_o(m_hlock), .m_hsel_o(m_hsel),
    .m_hrdata_i(m_hrdata), .m_hready_i(m_hready), .m_hresp_i(m_hresp)
  );

  ahb_rr_arbiter #(.NUM_MASTERS(3), .AW(32)) dut3 (
    .s_clk_i(clk), .s_resetn_i(resetn),
    .s_haddr_i(haddr3), .s_hwdata_i(hwdata3), .s_hsize_i(hsize3), .s_htrans_i(htrans3),
    .s_hwrite_i(hwrite3), .s_hmastlock_i(hlock3), .s_hsel_i(hsel3),
    .s_hrdata_o(hrdata3), .s_hready_o(hready3), .s_hresp_o(hresp3),
    .m_haddr_o(m_haddr3), .m_hwdata_o(m_hwdata3), .m_hsize_o(m_hsize3), .m_htrans_o(m_htrans3),
    .m_hwrite_o(m_hwrite3), .m_hmastlock_o(m_hlock3), .m_hsel_o(m_hsel3),
    .m_hrdata_i(32'h0), .m_hready_i(1'b1), .m_hresp_i(1'b0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      haddr[i] = '0; hwdata[i] = '0; hsize[i] = 3'd2; htrans[i] = 2'd0;
      hwrite[i] = 1'b0; hlock[i] = 1'b0; hsel[i] = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      haddr3[i] = '0; hwdata3[i] = '0; hsize3[i] = 3'd2; htrans3[i] = 2'd0;
      hwrite3[i] = 1'b0; hlock3[i] = 1'b0; hsel3[i] = 1'b0;
    end
    m_hready = 1'b1; m_hresp = 1'b0; m_hrdata = '0;
  endtask

  task automatic master_req(input int m, input logic [31:0] a, input logic w, input logic lk);
    hsel[m] = 1'b1; htrans[m] = 2'd2; haddr[m] = a; hwrite[m] = w; hlock[m] = lk;
  endtask

  task automatic master_idle(input int m);
    htrans[m] = 2'd0; hlock[m] = 1'b0;
  endtask

  task automatic apply_reset();
    idle_all();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    idle_all();
    resetn = 1'b0;
    step();
    step();
    settle();
    n_tests++; if (m_htrans !== 2'd0) begin n_fail++; $display("FAIL reset_htrans: got %0d want 0", m_htrans); end
    n_tests++; if (m_hsel !== 1'b0) begin n_fail++; $display("FAIL reset_hsel: got %b want 0", m_hsel); end
    n_tests++; if (hready[0] !== 1'b1 || hready[1] !== 1'b1) begin n_fail++; $display("FAIL reset_hready: got %b%b want 11", hready[1], hready[0]); end
    n_tests++; if (hresp[0] !== 1'b0 || hresp[1] !== 1'b0) begin n_fail++; $display("FAIL reset_hresp: got %b%b want 00", hresp[1], hresp[0]); end
    n_tests++; if (m_htrans3 !== 2'd0) begin n_fail++; $display("FAIL reset_htrans3: got %0d want 0", m_htrans3); end
    step();
    resetn = 1'b1;
  endtask

  task automatic test_single_read();
    apply_reset();
    master_req(0, 32'h100, 1'b0, 1'b0);
    settle();
    n_tests++; if (m_haddr !== 32'h100) begin n_fail++; $display("FAIL single_addr: got %h want 00000100", m_haddr); end
    n_tests++; if (m_htrans !== 2'd2 || m_hsel !== 1'b1) begin n_fail++; $display("FAIL single_trans: got htrans=%0d hsel=%b want 2/1", m_htrans, m_hsel); end
    n_tests++; if (hready[0] !== 1'b1) begin n_fail++; $display("FAIL single_ready_a: got %b want 1", hready[0]); end
    step();
    master_idle(0);
    m_hrdata = 32'hCAFE0001;
    settle();
    n_tests++; if (hrdata[0] !== 32'hCAFE0001) begin n_fail++; $display("FAIL single_rdata: got %h want cafe0001", hrdata[0]); end
    n_tests++; if (hready[0] !== 1'b1) begin n_fail++; $display("FAIL single_ready_d: got %b want 1", hready[0]); end
    n_tests++; if (m_htrans !== 2'd0) begin n_fail++; $display("FAIL single_idle: got %0d want 0", m_htrans); end
    step();
  endtask

  task automatic test_pair();
    apply_reset();
    master_req(0, 32'h200, 1'b0, 1'b0);
    master_req(1, 32'h300, 1'b1, 1'b0);
    settle();
    n_tests++; if (m_haddr !== 32'h200) begin n_fail++; $display("FAIL pair_first: got %h want 00000200", m_haddr); end
    step();
    master_req(0, 32'h204, 1'b0, 1'b0);
    master_idle(1);
    hwdata[1] = 32'h11112222;
    settle();
    n_tests++; if (hready[1] !== 1'b0) begin n_fail++; $display("FAIL pair_m1_stall: got %b want 0", hready[1]); end
    n_tests++; if (m_haddr !== 32'h300 || m_hwrite !== 1'b1) begin n_fail++; $display("FAIL pair_m1_replay: got %h w=%b want 00000300 w=1", m_haddr, m_hwrite); end
    n_tests++; if (hready[0] !== 1'b1) begin n_fail++; $display("FAIL pair_m0_data: got %b want 1", hready[0]); end
    step();
    master_idle(0);
    settle();
    n_tests++; if (m_haddr !== 32'h204 || m_htrans !== 2'd2) begin n_fail++; $display("FAIL pair_m0_second: got %h t=%0d want 00000204 t=2", m_haddr, m_htrans); end
    n_tests++; if (hready[0] !== 1'b0 || hready[1] !== 1'b1) begin n_fail++; $display("FAIL pair_ready: got m0=%b m1=%b want 0/1", hready[0], hready[1]); end
    n_tests++; if (m_hwdata !== 32'h11112222) begin n_fail++; $display("FAIL pair_hwdata: got %h want 11112222", m_hwdata); end
    step();
    settle();
    n_tests++; if (m_htrans !== 2'd0 || hready[0] !== 1'b1) begin n_fail++; $display("FAIL pair_drain: got t=%0d rdy0=%b want 0/1", m_htrans, hready[0]); end
    step();
  endtask

  task automatic test_round_robin3();
    logic [31:0] exp_addr [6];
    exp_addr = '{32'hA0, 32'hA1, 32'hA2, 32'hA0, 32'hA1, 32'hA2};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      hsel3[i] = 1'b1; htrans3[i] = 2'd2; haddr3[i] = 32'hA0 + i;
    end
    for (int c = 0; c < 6; c++) begin
      settle();
      n_tests++;
      if (m_haddr3 !== exp_addr[c] || m_htrans3 !== 2'd2) begin
        n_fail++; $display("FAIL rr3_cycle%0d: got %h t=%0d want %h t=2", c, m_haddr3, m_htrans3, exp_addr[c]);
      end
      step();
    end
    for (int i = 0; i < 3; i++) htrans3[i] = 2'd0;
    step();
    step();
  endtask

  task automatic test_locked_burst();
    apply_reset();
    master_req(0, 32'h400, 1'b1, 1'b1);
    master_req(1, 32'h500, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      settle();
      n_tests++;
      if (m_haddr !== 32'h400 + 4 * b || m_hlock !== 1'b1) begin
        n_fail++; $display("FAIL lock_beat%0d: got %h lock=%b want %h lock=1", b, m_haddr, m_hlock, 32'h400 + 4 * b);
      end
      if (b > 0) begin
        n_tests++; if (hready[1] !== 1'b0) begin n_fail++; $display("FAIL lock_m1_stall%0d: got %b want 0", b, hready[1]); end
      end
      step();
      if (b == 0) master_idle(1);
      if (b < 3) haddr[0] = 32'h400 + 4 * (b + 1);
      else master_idle(0);
    end
    settle();
    n_tests++; if (m_haddr !== 32'h500 || m_hlock !== 1'b0 || m_hwrite !== 1'b0) begin n_fail++; $display("FAIL lock_m1_after: got %h lock=%b w=%b want 00000500 0 0", m_haddr, m_hlock, m_hwrite); end
    step();
    settle();
    n_tests++; if (hready[1] !== 1'b1) begin n_fail++; $display("FAIL lock_m1_data: got %b want 1", hready[1]); end
    step();
  endtask

  task automatic test_wait_states();
    apply_reset();
    master_req(0, 32'h600, 1'b1, 1'b0);
    master_req(1, 32'h700, 1'b0, 1'b0);
    settle();
    n_tests++; if (m_haddr !== 32'h600) begin n_fail++; $display("FAIL ws_m0_addr: got %h want 00000600", m_haddr); end
    step();
    master_idle(0);
    master_idle(1);
    hwdata[0] = 32'hDEADBEEF;
    m_hready = 1'b0;
    for (int w = 0; w < 2; w++) begin
      settle();
      n_tests++; if (m_hwdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ws_hwdata%0d: got %h want deadbeef", w, m_hwdata); end
      n_tests++; if (hready[0] !== 1'b0 || hready[1] !== 1'b0) begin n_fail++; $display("FAIL ws_stall%0d: got m0=%b m1=%b want 0/0", w, hready[0], hready[1]); end
      step();
    end
    m_hready = 1'b1;
    settle();
    n_tests++; if (m_haddr !== 32'h700 || m_htrans !== 2'd2) begin n_fail++; $display("FAIL ws_m1_issue: got %h t=%0d want 00000700 t=2", m_haddr, m_htrans); end
    n_tests++; if (hready[0] !== 1'b1 || hready[1] !== 1'b0) begin n_fail++; $display("FAIL ws_release: got m0=%b m1=%b want 1/0", hready[0], hready[1]); end
    n_tests++; if (m_hwdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ws_hwdata_last: got %h want deadbeef", m_hwdata); end
    step();
    m_hrdata = 32'h5A5A0700;
    settle();
    n_tests++; if (hready[1] !== 1'b1 || hrdata[1] !== 32'h5A5A0700) begin n_fail++; $display("FAIL ws_m1_data: got rdy=%b rdata=%h want 1/5a5a0700", hready[1], hrdata[1]); end
    step();
  endtask

  task automatic test_error();
    apply_reset();
    master_req(1, 32'h800, 1'b0, 1'b0);
    settle();
    n_tests++; if (m_haddr !== 32'h800) begin n_fail++; $display("FAIL err_m1_addr: got %h want 00000800", m_haddr); end
    step();
    master_idle(1);
    master_req(0, 32'h900, 1'b0, 1'b0);
    m_hready = 1'b0;
    m_hresp  = 1'b1;
    settle();
    n_tests++; if (hresp[1] !== 1'b1 || hready[1] !== 1'b0) begin n_fail++; $display("FAIL err_c1_m1: got resp=%b rdy=%b want 1/0", hresp[1], hready[1]); end
    n_tests++; if (hresp[0] !== 1'b0) begin n_fail++; $display("FAIL err_c1_m0resp: got %b want 0", hresp[0]); end
    step();
    master_idle(0);
    m_hready = 1'b1;
    settle();
    n_tests++; if (hresp[1] !== 1'b1 || hready[1] !== 1'b1) begin n_fail++; $display("FAIL err_c2_m1: got resp=%b rdy=%b want 1/1", hresp[1], hready[1]); end
    n_tests++; if (hresp[0] !== 1'b0 || hready[0] !== 1'b0) begin n_fail++; $display("FAIL err_c2_m0: got resp=%b rdy=%b want 0/0", hresp[0], hready[0]); end
    n_tests++; if (m_haddr !== 32'h900 || m_htrans !== 2'd2) begin n_fail++; $display("FAIL err_m0_issue: got %h t=%0d want 00000900 t=2", m_haddr, m_htrans); end
    step();
    m_hresp = 1'b0;
    settle();
    n_tests++; if (hready[0] !== 1'b1 || hresp[0] !== 1'b0 || hresp[1] !== 1'b0) begin n_fail++; $display("FAIL err_after: got rdy0=%b resp0=%b resp1=%b want 1/0/0", hready[0], hresp[0], hresp[1]); end
    step();
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    master_req(0, 32'hA00, 1'b0, 1'b0);
    master_req(1, 32'hB00, 1'b0, 1'b0);
    step();
    master_idle(0);
    master_idle(1);
    resetn = 1'b0;
    step();
    settle();
    n_tests++; if (hready[1] !== 1'b1 || hready[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got m0=%b m1=%b want 1/1", hready[0], hready[1]); end
    n_tests++; if (m_htrans !== 2'd0 || m_hsel !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got t=%0d sel=%b want 0/0", m_htrans, m_hsel); end
    step();
    resetn = 1'b1;
    settle();
    n_tests++; if (m_htrans !== 2'd0) begin n_fail++; $display("FAIL midrst_noreplay: got %0d want 0", m_htrans); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_all();
    resetn = 1'b0;
    test_reset();
    test_single_read();
    test_pair();
    test_round_robin3();
    test_locked_burst();
    test_wait_states();
    test_error();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
